// File: rtl/c7bifu_pkg.sv
// Shared IFU constants and types for the c7bifu fetch front end.
package c7bifu_pkg;

    localparam int          C7B_INST_W      = 32;
    localparam int          C7B_ADDR_W      = 32;
    localparam int          C7B_FETCH_DEPTH = 4;
    localparam logic [31:0] C7B_RESET_PC    = 32'h1c00_0000;

    typedef struct packed {
        logic [C7B_ADDR_W-1:0] pc;
        logic [C7B_INST_W-1:0] inst;
    } fqEntry_t;

    function automatic logic [C7B_ADDR_W-1:0] alignPc(input logic [C7B_ADDR_W-1:0] pc);
        return {pc[C7B_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/c7bifu_fq.sv
// Fetch queue: synchronous FIFO of {pc, inst} with push, pop and clear (clear wins).
module c7bifu_fq
    import c7bifu_pkg::*;
#(
    parameter int DEPTH = C7B_FETCH_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [C7B_ADDR_W-1:0] pushPc_i,
    input  logic [C7B_INST_W-1:0] pushInst_i,
    input  logic                  pop_i,
    output logic [CW-1:0]         count_o,
    output logic                  headVld_o,
    output logic [C7B_ADDR_W-1:0] headPc_o,
    output logic [C7B_INST_W-1:0] headInst_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fqEntry_t        mem_q [DEPTH];
    logic [PW-1:0]   rdPtr_q, rdPtr_d;
    logic [PW-1:0]   wrPtr_q, wrPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            doPush;
    logic            doPop;
    logic            notEmpty;
    logic            full;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign notEmpty = (count_q != '0);
    assign full     = (count_q == CW'(DEPTH));
    assign doPop    = pop_i & notEmpty;
    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign doPush   = push_i & (~full | doPop);

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (clear_i) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) wrPtr_d = nextPtr(wrPtr_q);
            if (doPop)  rdPtr_d = nextPtr(rdPtr_q);
            case ({doPush, doPop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush & ~clear_i) begin
            mem_q[wrPtr_q] <= '{pc: pushPc_i, inst: pushInst_i};
        end
    end

    assign count_o    = count_q;
    assign headVld_o  = notEmpty;
    assign headPc_o   = notEmpty ? mem_q[rdPtr_q].pc   : '0;
    assign headInst_o = notEmpty ? mem_q[rdPtr_q].inst : '0;

endmodule

// File: rtl/c7bifu_fetch.sv
// IFU fetch front end: sequential ICU requests, in-order response matching,
// queueing toward decode, and flush redirect with dropping of stale responses.
module c7bifu_fetch
    import c7bifu_pkg::*;
#(
    parameter int          DEPTH    = C7B_FETCH_DEPTH,
    parameter logic [31:0] RESET_PC = C7B_RESET_PC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [C7B_ADDR_W-1:0] flush_pc,
    output logic                  fetch_icu_req,
    output logic [C7B_ADDR_W-1:0] fetch_icu_addr,
    input  logic                  icu_fetch_ack,
    input  logic                  icu_fetch_rsp_vld,
    input  logic [C7B_INST_W-1:0] icu_fetch_rsp_inst,
    output logic                  inst_vld_f,
    output logic [C7B_ADDR_W-1:0] inst_addr_f,
    output logic [C7B_INST_W-1:0] inst_f
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [C7B_ADDR_W-1:0] pc_q, pc_d;
    logic [C7B_ADDR_W-1:0] rspPc_q, rspPc_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic [CW-1:0]         dropCnt_q, dropCnt_d;
    logic [CW-1:0]         fqCount;
    logic [CW:0]           creditUsed;
    logic                  accept;
    logic                  pushRsp;
    logic                  popHead;
    logic                  headVld;
    logic [C7B_ADDR_W-1:0] redirectPc;

    assign redirectPc = alignPc(flush_pc);

    // Queued entries plus in-flight requests may never exceed the queue depth,
    // so every non-dropped response is guaranteed a free slot.
    assign creditUsed     = {1'b0, fqCount} + {1'b0, outstanding_q};
    assign fetch_icu_req  = ~reset & ~flush & (creditUsed < (CW + 1)'(DEPTH));
    assign fetch_icu_addr = pc_q;

    assign accept  = fetch_icu_req & icu_fetch_ack;
    assign pushRsp = icu_fetch_rsp_vld & ~flush & (dropCnt_q == '0);
    assign popHead = headVld & ~stall & ~flush;

    always_comb begin
        pc_d          = pc_q;
        rspPc_d       = rspPc_q;
        outstanding_d = outstanding_q;
        dropCnt_d     = dropCnt_q;

        case ({accept, icu_fetch_rsp_vld})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase

        if (flush) begin
            pc_d      = redirectPc;
            rspPc_d   = redirectPc;
            dropCnt_d = outstanding_q - CW'(icu_fetch_rsp_vld);
        end else begin
            if (accept)  pc_d    = pc_q + 32'd4;
            if (pushRsp) rspPc_d = rspPc_q + 32'd4;
            if (icu_fetch_rsp_vld && (dropCnt_q != '0)) dropCnt_d = dropCnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            rspPc_q       <= RESET_PC;
            outstanding_q <= '0;
            dropCnt_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            rspPc_q       <= rspPc_d;
            outstanding_q <= outstanding_d;
            dropCnt_q     <= dropCnt_d;
        end
    end

    c7bifu_fq #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) uFq (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (flush),
        .push_i     (pushRsp),
        .pushPc_i   (rspPc_q),
        .pushInst_i (icu_fetch_rsp_inst),
        .pop_i      (popHead),
        .count_o    (fqCount),
        .headVld_o  (headVld),
        .headPc_o   (inst_addr_f),
        .headInst_o (inst_f)
    );

    assign inst_vld_f = headVld;

endmodule

// File: tb/tb_c7bifu_fetch.sv
// Self-checking bench for c7bifu_fetch: ICU model plus decode-side scoreboard.
module tb_c7bifu_fetch;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic        stale;
    } icuEntry_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        fetch_icu_req;
    logic [31:0] fetch_icu_addr;
    logic        icu_fetch_ack;
    logic        icu_fetch_rsp_vld;
    logic [31:0] icu_fetch_rsp_inst;
    logic        inst_vld_f;
    logic [31:0] inst_addr_f;
    logic [31:0] inst_f;

    int          passCount;
    int          checkCount;
    bit          ackEn;
    bit          rspEn;
    icuEntry_t   icuQ[$];
    logic [63:0] sbQ[$];
    logic [31:0] expPc;
    int          acceptTally;
    int          popTally;
    logic [31:0] firstPopPc;
    logic [31:0] lastPopPc;

    c7bifu_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h1c00_0000)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .stall              (stall),
        .flush              (flush),
        .flush_pc           (flush_pc),
        .fetch_icu_req      (fetch_icu_req),
        .fetch_icu_addr     (fetch_icu_addr),
        .icu_fetch_ack      (icu_fetch_ack),
        .icu_fetch_rsp_vld  (icu_fetch_rsp_vld),
        .icu_fetch_rsp_inst (icu_fetch_rsp_inst),
        .inst_vld_f         (inst_vld_f),
        .inst_addr_f        (inst_addr_f),
        .inst_f             (inst_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instOf(input logic [31:0] a);
        return (a ^ 32'h5a5a_c3c3) + 32'h0000_1111;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int staleCount();
        int n = 0;
        foreach (icuQ[i]) if (icuQ[i].stale) n++;
        return n;
    endfunction

    // One clock of ICU/decode behaviour: drive response, check outputs, advance model.
    task automatic runCycle();
        bit          deliver;
        bit          expReq;
        bit          expVld;
        bit          doPop;
        logic [63:0] head;
        icuEntry_t   e;

        deliver            = rspEn && (icuQ.size() > 0);
        icu_fetch_rsp_vld  = deliver;
        icu_fetch_rsp_inst = deliver ? instOf(icuQ[0].pc) : 32'h0;
        icu_fetch_ack      = ackEn;
        #1;

        expReq = !flush && ((sbQ.size() + icuQ.size()) < DEPTH);
        checkOutput("req", 32'(fetch_icu_req), 32'(expReq));
        if (expReq) checkOutput("reqAddr", fetch_icu_addr, expPc);
        expVld = (sbQ.size() != 0);
        head   = expVld ? sbQ[0] : 64'h0;
        checkOutput("instVld", 32'(inst_vld_f), 32'(expVld));
        checkOutput("instAddr", inst_addr_f, head[63:32]);
        checkOutput("inst", inst_f, head[31:0]);
        checkOutput("creditBound", 32'((32'(dut.fqCount) + 32'(dut.outstanding_q)) <= DEPTH), 32'd1);
        if (deliver) begin
            checkOutput("rspOutstanding", 32'(dut.outstanding_q != 0), 32'd1);
            if (!icuQ[0].stale && !flush)
                checkOutput("rspNotFull", 32'(32'(dut.fqCount) < DEPTH), 32'd1);
        end

        doPop = expVld && !stall && !flush;
        if (doPop) begin
            if (popTally == 0) firstPopPc = head[63:32];
            lastPopPc = head[63:32];
            popTally++;
        end

        @(posedge clk);
        if (doPop) void'(sbQ.pop_front());
        if (deliver) begin
            e = icuQ.pop_front();
            if (!e.stale && !flush) sbQ.push_back({e.pc, instOf(e.pc)});
        end
        if (flush) begin
            sbQ.delete();
            foreach (icuQ[i]) icuQ[i].stale = 1'b1;
            expPc = {flush_pc[31:2], 2'b00};
        end else if (expReq && ackEn) begin
            icuQ.push_back('{pc: expPc, stale: 1'b0});
            expPc = expPc + 32'd4;
            acceptTally++;
        end
        #1;
    endtask

    task automatic applyStimulus(input bit st, input bit fl, input logic [31:0] fpc,
                                 input bit ack, input bit rspOn, input int cycles);
        stall    = st;
        flush    = fl;
        flush_pc = fpc;
        ackEn    = ack;
        rspEn    = rspOn;
        for (int c = 0; c < cycles; c++) runCycle();
        flush    = 1'b0;
        flush_pc = 32'h0;
    endtask

    initial begin
        passCount          = 0;
        checkCount         = 0;
        acceptTally        = 0;
        popTally           = 0;
        firstPopPc         = 32'h0;
        lastPopPc          = 32'h0;
        reset              = 1'b1;
        stall              = 1'b0;
        flush              = 1'b0;
        flush_pc           = 32'h0;
        ackEn              = 1'b0;
        rspEn              = 1'b0;
        icu_fetch_ack      = 1'b0;
        icu_fetch_rsp_vld  = 1'b0;
        icu_fetch_rsp_inst = 32'h0;
        expPc              = 32'h1c00_0000;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstReq", 32'(fetch_icu_req), 32'd0);
        checkOutput("rstAddr", fetch_icu_addr, 32'h1c00_0000);
        checkOutput("rstVld", 32'(inst_vld_f), 32'd0);
        checkOutput("rstInstAddr", inst_addr_f, 32'h0);
        checkOutput("rstInst", inst_f, 32'h0);
        reset = 1'b0;

        $display("[TB] fill with decode stalled");
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 8);
        checkOutput("fourAccepted", 32'(acceptTally), 32'd4);
        checkOutput("fullCount", 32'(dut.fqCount), 32'd4);

        $display("[TB] release stall and drain");
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 6);
        checkOutput("drainPops", 32'(popTally), 32'd4);
        checkOutput("firstDecoded", firstPopPc, 32'h1c00_0000);
        checkOutput("lastDecoded", lastPopPc, 32'h1c00_000c);

        $display("[TB] flush with three outstanding");
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 32'h1c00_0100, 1'b0, 1'b0, 1);
        checkOutput("dropCnt3", 32'(dut.dropCnt_q), 32'(staleCount()));
        checkOutput("dropCnt3Abs", 32'(dut.dropCnt_q), 32'd3);
        popTally = 0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 10);
        checkOutput("firstAfterFlush", firstPopPc, 32'h1c00_0100);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 6);

        $display("[TB] response coincident with flush");
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b1, 32'h1c00_0200, 1'b0, 1'b1, 1);
        checkOutput("dropCnt2", 32'(dut.dropCnt_q), 32'd2);
        checkOutput("outstanding2", 32'(dut.outstanding_q), 32'd2);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 3);
        checkOutput("outstandingZero", 32'(dut.outstanding_q), 32'd0);
        checkOutput("dropCntZero", 32'(dut.dropCnt_q), 32'd0);

        $display("[TB] push and pop together at count 2");
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 3);
        checkOutput("count2", 32'(dut.fqCount), 32'd2);
        checkOutput("headBefore", inst_addr_f, 32'h1c00_0200);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
        checkOutput("countHold", 32'(dut.fqCount), 32'd2);
        checkOutput("headAdvanced", inst_addr_f, 32'h1c00_0204);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4);

        $display("[TB] redirect near top of address space");
        applyStimulus(1'b1, 1'b1, 32'hffff_fffc, 1'b0, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 2);
        checkOutput("wrapPc", dut.pc_q, 32'h0000_0004);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 5);
        checkOutput("wrapDecoded", lastPopPc, 32'h0000_0000);

        $display("[TB] misaligned redirect target");
        applyStimulus(1'b0, 1'b1, 32'h1c00_0103, 1'b0, 1'b1, 1);
        checkOutput("alignedReq", fetch_icu_addr, 32'h1c00_0100);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 6);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 6);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/c7bifu_fetch.md
# c7bifu_fetch

Fetch front end of the c7bifu IFU: it generates sequential instruction-fetch requests to the instruction cache unit (ICU), matches in-order responses to their PCs, buffers them in a small queue, and presents them to the decode stage on the `inst_vld_f / inst_addr_f / inst_f` interface under decode's `stall / flush` control. On a flush it redirects to a new PC, empties the queue, and silently drops responses to requests that were already in flight.

## Interface

Parameters:
- `DEPTH`, 4: queue entries; also the cap on queued plus outstanding requests.
- `RESET_PC`, 32'h1c00_0000: first fetch PC after reset.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  decode stall; same signal decode uses.
- `flush`  in  1  pipeline flush/redirect; same signal decode uses.
- `flush_pc`  in  32  redirect target, valid with `flush`; bits [1:0] ignored and treated as 0.
- `fetch_icu_req`  out  1  fetch request valid.
- `fetch_icu_addr`  out  32  fetch request PC.
- `icu_fetch_ack`  in  1  request accepted this cycle.
- `icu_fetch_rsp_vld`  in  1  response valid; responses return in request order.
- `icu_fetch_rsp_inst`  in  32  response instruction word.
- `inst_vld_f`  out  1  head entry valid, to decode.
- `inst_addr_f`  out  32  head PC.
- `inst_f`  out  32  head instruction.

## Operation

State:
- `pc_q`: next request PC.
- `rsp_pc_q`: PC of the next expected response.
- `outstanding`: acked requests with no response yet.
- `drop_cnt`: responses still to be discarded.
- Queue `count`.

Counters are `$clog2(DEPTH+1)` bits wide.

- **Request.** `fetch_icu_req = ~flush & (count + outstanding < DEPTH)`. `fetch_icu_addr = pc_q`.
- **Request accept.** On `req & ack`, `pc_q += 4` (wraps modulo 2^32) and `outstanding++`.
- **Response with `drop_cnt != 0`.** Discarded; `drop_cnt--`, `outstanding--`.
- **Response with `drop_cnt == 0`.** Push `{rsp_pc_q, rsp_inst}`; `rsp_pc_q += 4`, `outstanding--`.
- **Pop.** Occurs when `inst_vld_f & ~stall & ~flush`, i.e. when decode captures the entry. Push and pop in the same cycle are both performed and `count` is unchanged.
- **Head outputs.** `inst_vld_f = (count != 0)`. `inst_addr_f` and `inst_f` show the head entry and are forced to 0 when empty.
- **Flush** has priority over every other event except reset:
  - queue emptied;
  - `pc_q <= flush_pc` and `rsp_pc_q <= flush_pc`;
  - `drop_cnt <= outstanding - (rsp_vld ? 1 : 0)`; a response arriving in the flush cycle is itself dropped;
  - `outstanding` is decremented for that response;
  - no request is issued in the flush cycle (`req = 0`), so an ack cannot coincide with a flush.
- **Flush while stalled.** Handled identically.
- **Reset:**
  - `pc_q = rsp_pc_q = RESET_PC`;
  - all counters 0, queue empty;
  - outputs `fetch_icu_req = 0`, `fetch_icu_addr = RESET_PC`, `inst_vld_f = 0`, `inst_addr_f = 0`, `inst_f = 0`.
- **Assertions.** The bench checks:
  - a non-dropped response never arrives when the queue is full (credit invariant);
  - `rsp_vld` never arrives with `outstanding == 0`;
  - `count + outstanding <= DEPTH` always.

## Timing

- Request ack at cycle N: next request carries `pc_q + 4` at N+1. Back-to-back fetch at one per cycle while credit allows.
- Response at cycle N into an empty queue: `inst_vld_f` high at N+1. No bypass.
- Pop at N: next entry presented at N+1.
- Flush at N:
  - `inst_vld_f = 0` at N+1;
  - the first request to `flush_pc` is issued at N+1;
  - the first post-flush instruction reaches decode no earlier than one cycle after its response.
- Full queue with `stall` held: `req` is deasserted. It reasserts the cycle after a pop frees credit.
- `count + outstanding == DEPTH`: `req` is low. A response in flight keeps `count + outstanding` constant; only a pop or a drop frees credit.

## Structure

- The shared IFU package holds:
  - `C7B_RESET_PC`, the `RESET_PC` default;
  - `C7B_FETCH_DEPTH`;
  - the instruction width constant.
- One sub-module, `c7bifu_fq`: a synchronous FIFO of `{pc, inst}` with push, pop and clear, exposing `count` and head. Clear has priority over push.
- The request/response/drop control stays in `c7bifu_fetch`.

## Test plan

- **Reset, ICU acks every cycle, rsp one cycle after ack.** Required: requests `0x1c000000, …04, …08, …0c`, then `req` drops with `stall` high. Once stall releases, decode sees the same PCs in order with the matching words.
- **Stall held, DEPTH=4.** Required: exactly 4 requests accepted. `req` stays low until the first pop, then rises one cycle later.
- **Three requests outstanding, flush with `flush_pc = 0x1c000100`.** Required: the 3 late responses are dropped and never appear on `inst_vld_f`. The first decoded PC after the flush is `0x1c000100`.
- **Response coincides with flush.** Required: that response is dropped, `drop_cnt` equals remaining outstanding, and `outstanding` reaches 0 after the drops.
- **Simultaneous push and pop with `count == 2`.** Required: `count` stays 2, the head advances by one PC, and ordering is preserved.
- **`flush_pc = 0xfffffffc`.** Required: the second request wraps to `0x00000000`.
- **`flush_pc = 0x1c000103`.** Required: the request is issued at `0x1c000100`.
